reset_sync_sequencer: RTL and testbench
=======================================

// Module: reset_sync_sequencer
// PURPOSE
//   Parametrised multi-channel reset synchroniser and release sequencer. Each reset-request
//   source passes through its own SYNC_DEPTH-flop synchroniser. A common FSM then holds every
//   output reset asserted for a minimum quiet window and releases the output resets in index
//   order, STAGGER_CYCLES apart. Sits at the SoC reset tree root, driving subsystem resets.
// PARAMETERS
//   NUM_CH         4   number of request inputs and output resets (>=1)
//   SYNC_DEPTH     3   synchroniser flops per request channel (>=2)
//   HOLD_CYCLES    16  consecutive quiet cycles required before release starts (>=1)
//   STAGGER_CYCLES 4   cycles between successive channel releases (>=1)
// PORTS
//   clock           in   1       single clock for the whole block
//   reset           in   1       synchronous, active-high
//   io_rst_req      in   NUM_CH  per-channel reset request, active-high, may be asynchronous
//   io_sw_rst       in   1       synchronous software reset pulse, active-high, not synchronised
//   io_rst_out      out  NUM_CH  subsystem resets, active-high, registered
//   io_all_released out  1       high only in RUN (all io_rst_out low)
//   io_busy         out  1       high in any state other than RUN
//   io_state        out  2       FSM state: 0=HOLD, 1=RELEASE, 2=RUN (3 unused)
// BEHAVIOUR
//   Reset: all synchroniser flops=1, io_rst_out=all 1s, state=HOLD, hold_cnt=0, idx=0,
//     stg_cnt=0; io_all_released=0, io_busy=1, io_state=0.
//   Sync: per channel shift chain; stage0<=io_rst_req[i], stage k<=stage k-1. req_s[i]=last stage.
//     Latency is SYNC_DEPTH edges. Define any_req = |req_s | io_sw_rst.
//   HOLD:
//     io_rst_out all 1s.
//     any_req -> hold_cnt<=0.
//     Else if hold_cnt==HOLD_CYCLES-1:
//       io_rst_out[0]<=0 and hold_cnt<=0.
//       If NUM_CH==1 -> RUN.
//       Else -> RELEASE with idx<=1, stg_cnt<=0.
//     Else hold_cnt++.
//   RELEASE:
//     any_req -> io_rst_out<=all 1s, state<=HOLD, hold_cnt<=0 (abort has priority).
//     Else if stg_cnt==STAGGER_CYCLES-1:
//       io_rst_out[idx]<=0 and stg_cnt<=0.
//       If idx==NUM_CH-1 -> RUN; else idx++.
//     Else stg_cnt++.
//     Channel k therefore falls STAGGER_CYCLES*k edges after channel 0.
//   RUN: io_rst_out all 0s; any_req -> io_rst_out<=all 1s, HOLD, hold_cnt<=0.
//   Assertion is immediate and global: any request reasserts every output on the next edge.
//     Release is always staged from channel 0. Once released, a channel never reasserts alone.
//   A request glitch shorter than one cycle may be missed; once sampled it is a full request.
//   Counter widths: hold_cnt clog2(HOLD_CYCLES+1), stg_cnt clog2(STAGGER_CYCLES+1),
//     idx clog2(NUM_CH+1). Counters never wrap; comparisons are equality-based.
//   reset has priority over everything, including mid-RELEASE: outputs return to all 1s
//     on the same edge.
// TESTING (NUM_CH=4, SYNC_DEPTH=3, HOLD_CYCLES=16, STAGGER_CYCLES=4 unless stated)
//   1 Power-up: reset 5 cycles, io_rst_req=0.
//     -> io_rst_out[0] falls at edge 19 after reset low; [1]@23, [2]@27, [3]@31.
//     -> io_all_released=1 from edge 31; io_state sequence 0,1,2.
//   2 Quiet-window restart: io_rst_req[2]=1 for one cycle at edge 10.
//     -> hold_cnt clears once req_s[2] is seen; rst_out[0] falls at edge 29 (not 19).
//   3 Abort mid-release: io_sw_rst=1 one cycle after rst_out[1] falls.
//     -> all outputs 1 next edge, state HOLD; release restarts from ch0 16 quiet cycles later.
//   4 Request in RUN: io_rst_req[3] rises.
//     -> all io_rst_out=1 exactly 4 edges later (3 sync + 1 register), io_busy=1.
//   5 reset asserted mid-RELEASE.
//     -> io_rst_out=4'hF, io_state=0, sync flops=1 on that edge; full sequence replays.
//   6 NUM_CH=1, STAGGER_CYCLES=1, HOLD_CYCLES=1.
//     -> HOLD goes directly to RUN; rst_out falls at edge 4 after reset low.

Source files
------------

// File: rtl/reset_sync_sequencer.sv
// Multi-channel reset synchroniser and staggered release sequencer.
// Requests are synchronised per channel; one FSM holds all resets, then releases them in index order.
module reset_sync_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_DEPTH     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] io_rst_req,
  input  logic              io_sw_rst,
  output logic [NUM_CH-1:0] io_rst_out,
  output logic              io_all_released,
  output logic              io_busy,
  output logic [1:0]        io_state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int IW = $clog2(NUM_CH + 1);

  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]     STG_LAST  = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ALL_ONES  = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] ALL_ZEROS = {NUM_CH{1'b0}};
  localparam logic [NUM_CH-1:0] CH0       = NUM_CH'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_DEPTH-1:0] sync [NUM_CH];
  logic [NUM_CH-1:0]     req_s;
  logic                  any_req;

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic [SW-1:0]     stg_cnt;
  logic [IW-1:0]     idx;
  logic [NUM_CH-1:0] rst_out;
  logic              all_released;
  logic              busy;

  // Per-channel synchroniser chains; they power up asserting a request.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        sync[i] <= {SYNC_DEPTH{1'b1}};
      end else begin
        sync[i] <= {sync[i][SYNC_DEPTH-2:0], io_rst_req[i]};
      end
    end
  end

  always_comb begin
    req_s = ALL_ZEROS;
    for (int i = 0; i < NUM_CH; i++) begin
      req_s[i] = sync[i][SYNC_DEPTH-1];
    end
  end

  assign any_req = (|req_s) | io_sw_rst;

  // Sequencer FSM: any request reasserts everything; release is always staged from channel 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_HOLD;
      rst_out      <= ALL_ONES;
      hold_cnt     <= HW'(0);
      stg_cnt      <= SW'(0);
      idx          <= IW'(0);
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          rst_out <= ALL_ONES;
          if (any_req) begin
            hold_cnt <= HW'(0);
          end else if (hold_cnt == HOLD_LAST) begin
            rst_out  <= ALL_ONES & ~CH0;
            hold_cnt <= HW'(0);
            if (NUM_CH == 1) begin
              state        <= ST_RUN;
              all_released <= 1'b1;
              busy         <= 1'b0;
            end else begin
              state   <= ST_RELEASE;
              idx     <= IW'(1);
              stg_cnt <= SW'(0);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          if (any_req) begin
            rst_out  <= ALL_ONES;
            state    <= ST_HOLD;
            hold_cnt <= HW'(0);
          end else if (stg_cnt == STG_LAST) begin
            rst_out <= rst_out & ~(CH0 << idx);
            stg_cnt <= SW'(0);
            if (idx == IDX_LAST) begin
              state        <= ST_RUN;
              all_released <= 1'b1;
              busy         <= 1'b0;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            stg_cnt <= stg_cnt + SW'(1);
          end
        end
        ST_RUN: begin
          if (any_req) begin
            rst_out      <= ALL_ONES;
            state        <= ST_HOLD;
            hold_cnt     <= HW'(0);
            all_released <= 1'b0;
            busy         <= 1'b1;
          end else begin
            rst_out <= ALL_ZEROS;
          end
        end
        default: begin
          rst_out      <= ALL_ONES;
          state        <= ST_HOLD;
          hold_cnt     <= HW'(0);
          all_released <= 1'b0;
          busy         <= 1'b1;
        end
      endcase
    end
  end

  assign io_rst_out      = rst_out;
  assign io_all_released = all_released;
  assign io_busy         = busy;
  assign io_state        = state;

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// Scoreboard bench: expected output transitions are queued per scenario and compared every cycle.
module tb_reset_sync_sequencer;

  logic       clock;
  logic       reset;
  logic [3:0] io_rst_req;
  logic       io_sw_rst;
  logic [3:0] io_rst_out;
  logic       io_all_released;
  logic       io_busy;
  logic [1:0] io_state;

  logic [0:0] req1;
  logic       sw1;
  logic [0:0] rst_out1;
  logic       all_rel1;
  logic       busy1;
  logic [1:0] state1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  reset_sync_sequencer #(.NUM_CH(4), .SYNC_DEPTH(3), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .io_rst_req(io_rst_req), .io_sw_rst(io_sw_rst),
    .io_rst_out(io_rst_out), .io_all_released(io_all_released), .io_busy(io_busy),
    .io_state(io_state)
  );

  reset_sync_sequencer #(.NUM_CH(1), .SYNC_DEPTH(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .io_rst_req(req1), .io_sw_rst(sw1),
    .io_rst_out(rst_out1), .io_all_released(all_rel1), .io_busy(busy1),
    .io_state(state1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.rst = r;
    e.st  = s;
    q.push_back(e);
  endtask

  // Each iteration observes the state left by one rising edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) cur = q.pop_front();
      checks++;
      if (io_rst_out !== cur.rst) begin
        errors++;
        $display("FAIL rst_out cyc=%0d got=%h exp=%h", cyc - base, io_rst_out, cur.rst);
      end
      checks++;
      if (io_state !== cur.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc - base, io_state, cur.st);
      end
      checks++;
      if (io_busy !== (cur.st != 2'd2) || io_all_released !== (cur.st == 2'd2)) begin
        errors++;
        $display("FAIL flags cyc=%0d busy=%b all_released=%b exp_state=%0d",
                 cyc - base, io_busy, io_all_released, cur.st);
      end
    end
  endtask

  task automatic do_reset();
    q.delete();
    cur.cyc = 0;
    cur.rst = 4'hF;
    cur.st  = 2'd0;
    reset = 1'b1;
    run_cycles(5);
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic push_release(input int b);
    push(b + 19, 4'hE, 2'd1);
    push(b + 23, 4'hC, 2'd1);
    push(b + 27, 4'h8, 2'd1);
    push(b + 31, 4'h0, 2'd2);
  endtask

  task automatic test_reset();
    io_rst_req = 4'h0;
    io_sw_rst  = 1'b0;
    req1       = 1'b0;
    sw1        = 1'b0;
    do_reset();
  endtask

  task automatic test_power_up();
    do_reset();
    push_release(base);
    run_cycles(35);
  endtask

  task automatic test_quiet_restart();
    do_reset();
    push_release(base + 10);
    run_cycles(9);
    io_rst_req[2] = 1'b1;
    run_cycles(1);
    io_rst_req[2] = 1'b0;
    run_cycles(35);
  endtask

  task automatic test_abort();
    do_reset();
    push_release(base);
    run_cycles(23);
    io_sw_rst = 1'b1;
    q.delete();
    push(base + 24, 4'hF, 2'd0);
    push_release(base + 21);
    run_cycles(1);
    io_sw_rst = 1'b0;
    run_cycles(32);
  endtask

  task automatic test_run_request();
    int c;
    int d;
    c = cyc;
    io_rst_req[3] = 1'b1;
    push(c + 4, 4'hF, 2'd0);
    run_cycles(10);
    d = cyc;
    io_rst_req[3] = 1'b0;
    push_release(d);
    run_cycles(35);
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    push_release(base);
    run_cycles(25);
    reset = 1'b1;
    q.delete();
    push(base + 26, 4'hF, 2'd0);
    run_cycles(3);
    reset = 1'b0;
    base = cyc;
    push_release(base);
    run_cycles(35);
  endtask

  task automatic test_single_channel();
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      run_cycles(1);
      checks++;
      if (rst_out1 !== ((e < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL ch1_rst_out edge=%0d got=%b exp=%b", e, rst_out1, (e < 4));
      end
      checks++;
      if (state1 !== ((e < 4) ? 2'd0 : 2'd2) || all_rel1 !== (e >= 4) || busy1 !== (e < 4)) begin
        errors++;
        $display("FAIL ch1_state edge=%0d got=%0d rel=%b busy=%b", e, state1, all_rel1, busy1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_power_up();
    test_quiet_restart();
    test_abort();
    test_run_request();
    test_reset_mid_release();
    test_single_channel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
